// File: rtl/ra_mult_seq.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes and the sign is restored on the last iteration.
module ra_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic [WIDTH-1:0] mplier;
    logic            neg;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last_iter;

    // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        if (is_signed && sv < 0) begin
            return WIDTH'(-sv);
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m,
                                                 input logic negate);
        logic signed [PW-1:0] sm;
        sm = signed'(m);
        return negate ? PW'(-sm) : m;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        last_iter = (cnt == CNT_LAST);
        addend    = mplier[0] ? mcand : '0;
        sum       = acc + addend;
        case (state)
            IDLE:    if (accept)    state_nxt = BUSY;
            BUSY:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                        mplier <= magnitude(b, signed_mode);
                        neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                // One multiplier bit per cycle; the count, not the operand value, ends the loop.
                BUSY: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        product <= apply_sign(sum, neg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ra_mult_seq.sv
// Scoreboard bench for ra_mult_seq: directed WIDTH=8 cases plus random sweeps at WIDTH=2, 8 and 16.
module tb_ra_mult_seq;

    logic clk = 1'b0;
    logic rst;

    logic        iv2, ir2, ov2, or2, sm2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic        iv8, ir8, ov8, or8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        iv16, ir16, ov16, or16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic [63:0] exp_q[$];
    logic [63:0] p_before;
    int unsigned cyc_cnt = 0;
    int unsigned accept_cyc;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    ra_mult_seq #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .signed_mode(sm2), .out_valid(ov2), .out_ready(or2), .product(p2)
    );
    ra_mult_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8)
    );
    ra_mult_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16)
    );

    function automatic logic [63:0] model(int w, logic [31:0] av, logic [31:0] bv, logic s);
        logic [63:0] mask;
        logic [63:0] r;
        longint      x;
        longint      y;
        mask = (64'd1 << w) - 64'd1;
        x = longint'({32'd0, av} & mask);
        y = longint'({32'd0, bv} & mask);
        if (s && av[w-1]) x = x - longint'(64'd1 << w);
        if (s && bv[w-1]) y = y - longint'(64'd1 << w);
        r = 64'(x * y);
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic f_ir(int w);
        case (w)
            2:       return ir2;
            8:       return ir8;
            default: return ir16;
        endcase
    endfunction

    function automatic logic f_ov(int w);
        case (w)
            2:       return ov2;
            8:       return ov8;
            default: return ov16;
        endcase
    endfunction

    function automatic logic [63:0] f_prod(int w);
        case (w)
            2:       return {60'd0, p2};
            8:       return {48'd0, p8};
            default: return {32'd0, p16};
        endcase
    endfunction

    task automatic set_in(int w, logic v, logic [31:0] av, logic [31:0] bv, logic s);
        case (w)
            2:       begin iv2 = v;  a2 = av[1:0];   b2 = bv[1:0];   sm2 = s;  end
            8:       begin iv8 = v;  a8 = av[7:0];   b8 = bv[7:0];   sm8 = s;  end
            default: begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; sm16 = s; end
        endcase
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the operands are accepted at the following posedge.
    task automatic start_op(int w, logic [31:0] av, logic [31:0] bv, logic s);
        int n = 0;
        while (!f_ir(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(n < 50), 64'd1);
        set_in(w, 1'b1, av, bv, s);
        exp_q.push_back(model(w, av, bv, s));
        p_before = f_prod(w);
        accept_cyc = cyc_cnt;
    endtask

    // Returns at the negedge of the first DONE cycle.
    task automatic wait_done(int w);
        int   cyc;
        logic held = 1'b1;
        logic [63:0] e;
        @(negedge clk);
        cyc = 0;
        while (!f_ov(w) && cyc < w + 4) begin
            if (f_prod(w) !== p_before) held = 1'b0;
            set_in(w, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            cyc++;
        end
        set_in(w, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("latency", 64'(cyc), 64'(w));
        chk("prod_hold_busy", 64'(held), 64'd1);
        chk("in_ready_in_done", 64'(f_ir(w)), 64'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        chk("product", f_prod(w), e);
    endtask

    task automatic finish_op(int w);
        @(negedge clk);
        chk("ov_fall", 64'(f_ov(w)), 64'd0);
        chk("in_ready_back", 64'(f_ir(w)), 64'd1);
    endtask

    task automatic do_op(int w, logic [31:0] av, logic [31:0] bv, logic s);
        start_op(w, av, bv, s);
        wait_done(w);
        finish_op(w);
    endtask

    initial begin
        logic [31:0] ra, rb, mask, msb;
        logic        rs;
        logic        seen;
        int unsigned t0;
        int          ws[3];

        rst = 1'b1;
        set_in(2, 1'b0, 0, 0, 1'b0);
        set_in(8, 1'b0, 0, 0, 1'b0);
        set_in(16, 1'b0, 0, 0, 1'b0);
        or2 = 1'b1; or8 = 1'b1; or16 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(ir8), 64'd0);
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_product", f_prod(8), 64'd0);
        chk("rst_product_w16", f_prod(16), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(ir8), 64'd1);

        do_op(8, 32'd255, 32'd255, 1'b0);
        chk("u255x255", f_prod(8), 64'hFE01);
        t0 = accept_cyc;
        do_op(8, 32'h80, 32'h80, 1'b1);
        chk("rate", 64'(accept_cyc - t0), 64'd10);
        chk("s_min_x_min", f_prod(8), 64'h4000);
        do_op(8, 32'hFF, 32'h7F, 1'b1);
        chk("s_m1_x_127", f_prod(8), 64'hFF81);
        do_op(8, 32'h00, 32'hFF, 1'b0);
        chk("zero_x_ff", f_prod(8), 64'h0);
        do_op(8, 32'h80, 32'h7F, 1'b0);
        chk("u128x127", f_prod(8), 64'h3F80);

        // Backpressure: DONE held for several cycles while new operands are offered.
        or8 = 1'b0;
        start_op(8, 32'd13, 32'd11, 1'b0);
        wait_done(8);
        for (int i = 0; i < 5; i++) begin
            set_in(8, 1'b1, $urandom, $urandom, 1'b1);
            @(negedge clk);
            chk("bp_out_valid", 64'(ov8), 64'd1);
            chk("bp_product", f_prod(8), 64'd143);
            chk("bp_in_ready", 64'(ir8), 64'd0);
        end
        set_in(8, 1'b0, 0, 0, 1'b0);
        or8 = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 64'(ov8), 64'd0);
        chk("bp_release_ir", 64'(ir8), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        chk("bp_no_phantom_op", 64'(seen), 64'd0);

        // Reset during iteration 4 abandons the operation.
        start_op(8, 32'd200, 32'd3, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clk);
        set_in(8, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ov", 64'(ov8), 64'd0);
        chk("midrst_product", f_prod(8), 64'd0);
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        chk("midrst_no_ov", 64'(seen), 64'd0);
        do_op(8, 32'd200, 32'd3, 1'b0);
        chk("after_rst_200x3", f_prod(8), 64'd600);

        ws[0] = 2; ws[1] = 8; ws[2] = 16;
        for (int k = 0; k < 3; k++) begin
            mask = 32'((64'd1 << ws[k]) - 64'd1);
            msb  = 32'd1 << (ws[k] - 1);
            for (int i = 0; i < 20; i++) begin
                case (i)
                    0, 1:    begin ra = mask; rb = mask; end
                    2, 3:    begin ra = msb;  rb = msb;  end
                    4, 5:    begin ra = msb;  rb = mask; end
                    default: begin ra = $urandom & mask; rb = $urandom & mask; end
                endcase
                rs = (i < 6) ? i[0] : 1'($urandom_range(0, 1));
                do_op(ws[k], ra, rb, rs);
            end
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ra_mult_seq.md
RA_MULT_SEQ -- requirements
Module: ra_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range SHALL be 2..32.
REQ-002 clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operands and mode are valid this cycle.
REQ-005 in_ready  output  1  the block can accept operands this cycle.
REQ-006 a  input  WIDTH  the multiplicand.
REQ-007 b  input  WIDTH  the multiplier.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands; it SHALL be sampled with a and b.
REQ-009 out_valid  output  1  the product is valid.
REQ-010 out_ready  input  1  the consumer accepts the product this cycle.
REQ-011 product  output  2*WIDTH  the result; two's-complement when the captured signed_mode is 1.

Function
REQ-012 The block SHALL be an iterative shift-add multiplier with three states: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE while rst is low; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, an accept (in_valid & in_ready) at edge E0 SHALL:
- capture a, b and signed_mode;
- clear the accumulator and the iteration counter;
- move the state to BUSY.
REQ-015 With no accept, IDLE SHALL hold its state and ignore all inputs.
REQ-016 In signed mode, the operand magnitudes SHALL be multiplied. The result SHALL be negated when the operand signs differ, and only then.
REQ-017 The most-negative operand, -2^(WIDTH-1), SHALL be handled correctly: its magnitude is 2^(WIDTH-1), which fits in WIDTH unsigned bits.
REQ-018 In unsigned mode, no sign processing SHALL occur.
REQ-019 BUSY SHALL perform exactly one iteration per cycle at edges E1..E_WIDTH. Each iteration:
- adds the shifted multiplicand magnitude when the current multiplier bit is 1;
- then advances to the next multiplier bit.
REQ-020 Zero or sparse operands SHALL NOT end BUSY early.
REQ-021 At edge E_WIDTH:
- the final value, including the sign correction, SHALL be written to product;
- the state SHALL move to DONE.
REQ-022 out_valid SHALL therefore rise exactly WIDTH cycles after the accept edge.
REQ-023 The sustained rate SHALL be one operation per WIDTH+2 cycles with out_ready held at 1.
REQ-024 In DONE, product and out_valid SHALL stay stable until out_ready is 1. On that edge, the state SHALL move to IDLE and out_valid SHALL fall.
REQ-025 The registered product SHALL keep its last value in IDLE and BUSY, and SHALL change only at the E_WIDTH edge.
REQ-026 The product width SHALL be 2*WIDTH. No overflow is possible, for example (2^WIDTH-1)^2 < 2^(2*WIDTH).
REQ-027 The accumulator SHALL have at least 2*WIDTH bits. There SHALL be no truncation of intermediate sums.
REQ-028 in_valid SHALL be ignored outside IDLE; operands presented in BUSY or DONE SHALL be dropped.
REQ-029 out_ready asserted outside DONE SHALL have no effect.
REQ-030 In the same cycle as a DONE→IDLE handshake, in_ready SHALL be 0. The next operation SHALL be accepted no earlier than the following cycle.

Reset
REQ-031 While rst is 1, at each rising edge:
- the state SHALL become IDLE;
- out_valid and in_ready SHALL be 0;
- product, the accumulator, the counter and the captured operands SHALL all be 0.
REQ-032 A reset asserted in BUSY or DONE SHALL abandon the operation. No out_valid pulse SHALL follow.
REQ-033 in_ready SHALL rise in the first cycle after rst falls.
REQ-034 rst SHALL have priority over every handshake input.

Verification
REQ-035 Unsigned, WIDTH=8: a=255, b=255, signed_mode=0 -> product=0xFE01 (65025), out_valid rising exactly 8 cycles after the accept edge.
REQ-036 Signed, WIDTH=8: a=0x80 (-128), b=0x80 -> product=0x4000 (16384); a=0xFF (-1), b=0x7F (127) -> product=0xFF81 (-127).
REQ-037 Backpressure: out_ready held 0 for 5 cycles in DONE -> product and out_valid stay stable, and in_valid pulses in those cycles are not accepted; out_ready=1 -> IDLE on the next edge, with in_ready=1 one cycle later.
REQ-038 Reset mid-operation: rst=1 for 1 cycle at iteration 4 of a=200, b=3 -> IDLE, product=0, no out_valid; a new a=200, b=3 -> product=600.
REQ-039 Zero and parameter sweep: a=0, b=0xFF -> product=0 after the full WIDTH latency; a self-checking random run against a reference model of a*b in both modes for WIDTH=2, 8 and 16 -> all results match.
